// File: rtl/keypad_pkg.sv
// Types and constants shared by the keypad scanner, this debouncer and the
// seven-segment display driver.
package keypad_pkg;

   localparam int unsigned KEY_CODE_W = 4;

   typedef logic [KEY_CODE_W-1:0] key_code_t;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } debounce_state_t;

endpackage

// File: rtl/debounce_timer.sv
// Stability counter for the keypad debouncer: clr restarts the count, inc advances it,
// and done flags the final stable sample.
module debounce_timer #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] count;

   assign done = (count == LAST);

   // The FSM leaves its wait state when done is high, so holding at LAST never loses a count.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !done) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces press and release of the scanner's decoded key and emits one strobe per press.
// Also keeps the newest and previous key codes for the two-digit display.
module keypad_debouncer
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic      clk,
   input  logic      rst,
   input  key_code_t key_code,
   input  logic      key_pressed,
   input  logic      key_valid,
   output logic      key_strobe,
   output key_code_t key_out,
   output logic      key_held,
   output key_code_t digit_new,
   output key_code_t digit_old
);

   debounce_state_t state, state_d;
   key_code_t       candidate;
   logic            press_sample;
   logic            match;
   logic            start;
   logic            fire;
   logic            clr;
   logic            inc;
   logic            done;

   assign press_sample = key_pressed && key_valid;
   assign match        = press_sample && (key_code == candidate);

   debounce_timer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (inc),
      .done(done)
   );

   always_comb begin
      state_d = state;
      start   = 1'b0;
      fire    = 1'b0;
      clr     = 1'b0;
      inc     = 1'b0;
      unique case (state)
         IDLE: begin
            if (press_sample) begin
               start   = 1'b1;
               clr     = 1'b1;
               state_d = PRESS_WAIT;
            end
         end
         PRESS_WAIT: begin
            if (!match) begin
               clr     = 1'b1;
               state_d = IDLE;
            end else if (done) begin
               fire    = 1'b1;
               state_d = HELD;
            end else begin
               inc = 1'b1;
            end
         end
         HELD: begin
            // Code changes or a second key while held are deliberately ignored.
            if (!key_pressed) begin
               clr     = 1'b1;
               state_d = RELEASE_WAIT;
            end
         end
         RELEASE_WAIT: begin
            if (key_pressed) begin
               clr     = 1'b1;
               state_d = HELD;
            end else if (done) begin
               state_d = IDLE;
            end else begin
               inc = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         candidate  <= '0;
         key_strobe <= 1'b0;
         key_out    <= '0;
         key_held   <= 1'b0;
         digit_new  <= '0;
         digit_old  <= '0;
      end else begin
         state      <= state_d;
         key_strobe <= fire;
         key_held   <= (state_d == HELD) || (state_d == RELEASE_WAIT);
         if (start) begin
            candidate <= key_code;
         end
         if (fire) begin
            key_out   <= candidate;
            digit_old <= digit_new;
            digit_new <= candidate;
         end
      end
   end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer at DEBOUNCE_CYCLES=4, plus a DEBOUNCE_CYCLES=1 instance.
module tb_keypad_debouncer;
   import keypad_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   key_code_t key_code;
   logic      key_pressed;
   logic      key_valid;
   logic      key_strobe;
   key_code_t key_out;
   logic      key_held;
   key_code_t digit_new;
   key_code_t digit_old;

   logic      strobe1;
   key_code_t key_out1;
   logic      key_held1;
   key_code_t digit_new1;
   key_code_t digit_old1;

   int errors     = 0;
   int checks     = 0;
   int strobe_cnt = 0;

   always #5 clk = ~clk;

   keypad_debouncer #(
      .DEBOUNCE_CYCLES(4)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .key_code   (key_code),
      .key_pressed(key_pressed),
      .key_valid  (key_valid),
      .key_strobe (key_strobe),
      .key_out    (key_out),
      .key_held   (key_held),
      .digit_new  (digit_new),
      .digit_old  (digit_old)
   );

   keypad_debouncer #(
      .DEBOUNCE_CYCLES(1)
   ) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .key_code   (key_code),
      .key_pressed(key_pressed),
      .key_valid  (key_valid),
      .key_strobe (strobe1),
      .key_out    (key_out1),
      .key_held   (key_held1),
      .digit_new  (digit_new1),
      .digit_old  (digit_old1)
   );

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic s, input logic [3:0] o,
                             input logic h, input logic [3:0] dn, input logic [3:0] dold);
      check({tag, ".strobe"}, {3'b0, key_strobe}, {3'b0, s});
      check({tag, ".key_out"}, key_out, o);
      check({tag, ".held"}, {3'b0, key_held}, {3'b0, h});
      check({tag, ".digit_new"}, digit_new, dn);
      check({tag, ".digit_old"}, digit_old, dold);
   endtask

   // Advance n edges, sampling 1 time unit after each and tallying strobes.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (key_strobe) strobe_cnt++;
      end
   endtask

   task automatic drive(input logic [3:0] code, input logic p, input logic v);
      key_code    = code;
      key_pressed = p;
      key_valid   = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      drive(4'h5, 1'b1, 1'b1);

      // 1: reset with a key down, then first debounced press
      tick(1);
      check_outs("rst_c1", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      tick(1);
      check_outs("rst_c2", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      check("d1_rst", {3'b0, strobe1}, 4'h0);
      rst = 1'b0;
      tick(1);
      check("d1_e1", {3'b0, strobe1}, 4'h0);
      tick(1);
      check("d1_e2", {3'b0, strobe1}, 4'h1);
      check("p1_e2", {3'b0, key_strobe}, 4'h0);
      tick(2);
      check("p1_e4_strobe", {3'b0, key_strobe}, 4'h0);
      check("p1_e4_held", {3'b0, key_held}, 4'h0);
      tick(1);
      check_outs("p1_e5", 1'b1, 4'h5, 1'b1, 4'h5, 4'h0);

      // 2: keep holding, strobe must not repeat
      tick(1);
      check_outs("p1_after", 1'b0, 4'h5, 1'b1, 4'h5, 4'h0);
      tick(18);
      check("p1_strobes", 4'(strobe_cnt), 4'h1);
      drive(4'h0, 1'b0, 1'b0);
      tick(4);
      check("r1_e4_held", {3'b0, key_held}, 4'h1);
      tick(1);
      check("r1_e5_held", {3'b0, key_held}, 4'h0);

      // 3: bouncy press of 5
      strobe_cnt = 0;
      drive(4'h5, 1'b1, 1'b1);
      tick(2);
      drive(4'h5, 1'b0, 1'b0);
      tick(1);
      drive(4'h5, 1'b1, 1'b1);
      tick(4);
      check("b_e4_strobe", {3'b0, key_strobe}, 4'h0);
      tick(1);
      check_outs("b_e5", 1'b1, 4'h5, 1'b1, 4'h5, 4'h5);
      tick(5);
      check("b_strobes", 4'(strobe_cnt), 4'h1);

      // 4: release bounce, then press A
      strobe_cnt = 0;
      drive(4'h5, 1'b0, 1'b0);
      tick(2);
      drive(4'h5, 1'b1, 1'b1);
      tick(1);
      check("rb_back_held", {3'b0, key_held}, 4'h1);
      drive(4'h5, 1'b0, 1'b0);
      tick(4);
      check("rb_e4_held", {3'b0, key_held}, 4'h1);
      tick(1);
      check("rb_e5_held", {3'b0, key_held}, 4'h0);
      check("rb_strobes", 4'(strobe_cnt), 4'h0);
      drive(4'hA, 1'b1, 1'b1);
      tick(4);
      check("a_e4_strobe", {3'b0, key_strobe}, 4'h0);
      tick(1);
      check_outs("a_e5", 1'b1, 4'hA, 1'b1, 4'hA, 4'h5);
      drive(4'h0, 1'b0, 1'b0);
      tick(5);
      check("a_rel_held", {3'b0, key_held}, 4'h0);

      // 5: code change mid-debounce; first 7 edge is a non-match that drops back to IDLE
      strobe_cnt = 0;
      drive(4'h3, 1'b1, 1'b1);
      tick(3);
      drive(4'h7, 1'b1, 1'b1);
      tick(5);
      check("cc_strobes", 4'(strobe_cnt), 4'h0);
      tick(1);
      check_outs("cc_fire", 1'b1, 4'h7, 1'b1, 4'h7, 4'hA);
      drive(4'h0, 1'b0, 1'b0);
      tick(5);

      // 6: reset while held with key still down
      drive(4'h9, 1'b1, 1'b1);
      tick(5);
      check_outs("h9_fire", 1'b1, 4'h9, 1'b1, 4'h9, 4'h7);
      tick(3);
      check("h9_held", {3'b0, key_held}, 4'h1);
      rst = 1'b1;
      tick(1);
      check_outs("h9_rst", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      rst = 1'b0;
      tick(4);
      check("h9_re_e4", {3'b0, key_strobe}, 4'h0);
      tick(1);
      check_outs("h9_re_e5", 1'b1, 4'h9, 1'b1, 4'h9, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
